// File: rtl/ccg_response_misr.sv
// Response compactor: folds accepted CUT responses into a MISR and checks the result against a golden signature.
// Optional build macro CCG_MISR_XMASK_EN adds resp_mask to exclude unknown CUT outputs from compaction.
module ccg_response_misr #(
  parameter int unsigned       WIDTH = 15,
  parameter int unsigned       CNT_W = 16,
  parameter logic [WIDTH-1:0]  POLY  = 15'h0003,
  parameter logic [WIDTH-1:0]  SEED  = 15'h0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_patterns,
  input  logic [WIDTH-1:0] golden,
  input  logic             resp_valid,
  input  logic [WIDTH-1:0] resp_data,
`ifdef CCG_MISR_XMASK_EN
  input  logic [WIDTH-1:0] resp_mask,
`endif
  output logic             resp_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature,
  output logic [CNT_W-1:0] accepted
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sig_q, sig_d;
  logic [CNT_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   golden_q, golden_d;
  logic               busy_q, done_q, pass_q;
  logic [WIDTH-1:0]   beat;

`ifdef CCG_MISR_XMASK_EN
  assign beat = resp_data & ~resp_mask;
`else
  assign beat = resp_data;
`endif

  always_comb begin
    state_d  = state_q;
    sig_d    = sig_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    golden_d = golden_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          sig_d    = SEED;
          acc_d    = '0;
          rem_d    = num_patterns;
          golden_d = golden;
          state_d  = (num_patterns == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        // abort takes priority over a beat offered in the same cycle
        if (abort) begin
          state_d = S_IDLE;
        end else if (resp_valid) begin
          sig_d = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ beat;
          acc_d = (acc_q == '1) ? acc_q : acc_q + CNT_W'(1);
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status flags are registered from the next-state values so they track the state with no extra cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sig_q    <= SEED;
      acc_q    <= '0;
      rem_q    <= '0;
      golden_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sig_q    <= sig_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      golden_q <= golden_d;
      busy_q   <= (state_d == S_RUN);
      done_q   <= (state_d == S_DONE);
      pass_q   <= (state_d == S_DONE) && (sig_d == golden_d);
    end
  end

  assign resp_ready = busy_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign signature  = sig_q;
  assign accepted   = acc_q;

endmodule
